interrupt_ctrl: RTL
===================

# interrupt_ctrl

Interrupt controller that sits directly upstream of the CPU core and drives its `req_interrupt` input. It collects `NUM_SRC` asynchronous interrupt lines, synchronises them, and detects edge or level events per source. It applies a software-written mask, selects the lowest-numbered pending unmasked source, and holds a request/acknowledge/end-of-interrupt handshake with the core. One interrupt is in service at a time; there is no nesting.

## Interface
Parameters:
- `NUM_SRC`, default 8: number of interrupt sources, range 2..32.
- `SYNC_STAGES`, default 2: flop stages in each input synchroniser, minimum 2.
- `VEC_W` is derived, not overridable: `$clog2(NUM_SRC)`.

Ports:
- `clk`  in  1  core clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_in`  in  NUM_SRC  raw asynchronous interrupt lines, active high.
- `edge_mode`  in  NUM_SRC  per-source mode, quasi-static: 1 = rising-edge triggered, 0 = level triggered.
- `mask_wr_en`  in  1  loads `mask_wr_data` into the mask register this cycle.
- `mask_wr_data`  in  NUM_SRC  new mask value; 1 = masked.
- `irq_ack`  in  1  CPU accepts the current request.
- `irq_done`  in  1  CPU end-of-interrupt.
- `req_interrupt`  out  1  to CPU `req_interrupt`.
- `irq_vector`  out  VEC_W  index of the requested or in-service source.
- `pending`  out  NUM_SRC  raw pending register, for debug and status reads.

## Operation
- **Reset values:** `req_interrupt`=0, `irq_vector`=0, `pending`=0, mask=all ones, all synchroniser flops=0, FSM=IDLE.
- **Synchroniser:** each `src_in` bit passes through `SYNC_STAGES` flops to give `sync`. `sync_d` is `sync` delayed by one cycle.
- **Edge source:** `pending[i]` is set when `sync[i] & ~sync_d[i]`. It is cleared on the cycle `irq_ack` is accepted with `irq_vector==i`. If set and clear land on the same cycle, set wins.
- **Level source:** `pending[i]` equals the registered `sync[i]`. Ack does not clear it; the source must deassert.
- **Eligible set:** `pending & ~mask`. Priority goes to the lowest index.
- **FSM:**
  - IDLE: if the eligible set is non-zero, latch `irq_vector` = lowest eligible index and go to REQ.
  - REQ: `req_interrupt`=1 and `irq_vector` is frozen. `irq_ack`=1 moves to SERVICE. The request is never withdrawn once raised, even if the source is later masked or a level source drops; the CPU handles spurious entries.
  - SERVICE: `req_interrupt`=0 and `irq_vector` is held. `irq_done`=1 moves to IDLE.
- **Ignored inputs:** `irq_ack` outside REQ and `irq_done` outside SERVICE. If both are asserted in REQ, only ack is taken.
- **Mask writes:** accepted in any state and take effect on the next eligibility evaluation.
- **Sizing:** `irq_vector` is zero-extended to VEC_W. If `NUM_SRC` is not a power of two, the unused vector codes are never produced.

## Timing
- `req_interrupt` and `irq_vector` are registered outputs with no combinational path from any input.
- **Latency:** let src rise so it is captured at edge k, with edge mode and the source unmasked. Then `pending` sets at edge k+SYNC_STAGES and `req_interrupt` rises at edge k+SYNC_STAGES+1, which is 4 edges at the default.
- **Ack:** `irq_ack` sampled high at edge n in REQ gives `req_interrupt`=0 after edge n. The pending clear for an edge source also happens at edge n.
- **Done:** `irq_done` sampled at edge m in SERVICE gives IDLE after edge m. The earliest next request is after edge m+1, so there is a minimum one-cycle gap with `req_interrupt` low.
- **Edge pulses:** a `src_in` pulse shorter than one clock may be missed; sources must hold for at least 2 cycles.
- **Reset:** `rst_n` low at any time, including mid-REQ or mid-SERVICE, immediately drives all outputs to their reset values. Release is synchronised by the top level.

## Structure
- Shared package `pkg_cpu` holds:
  - `typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_SERVICE} IrqState`
  - the constant `CPU_NUM_IRQ_SRC` = 8, used as the top-level `NUM_SRC`.
- One sub-module, `irq_sync`: a parameterised `SYNC_STAGES`-deep synchroniser with `rst_n`, instantiated once with width NUM_SRC.
- The priority encoder is a function within `interrupt_ctrl`.

## Test plan
- **Reset:** after reset, pulse `src_in[3]` (edge mode, mask all ones) for 3 cycles -> `req_interrupt` stays 0 and `pending`=8'h08. Then write mask=8'hF7 -> `req_interrupt` rises 2 edges later with `irq_vector`=3.
- **Priority:** raise `src_in[5]` and `src_in[2]` together, mask=0, both edge mode -> vector=2. Ack then done -> the second request carries vector=5 after a gap of at least 1 low cycle.
- **Level source:** `src_in[1]` is level and held high; ack then done -> it re-requests vector=1. Deassert during SERVICE -> no new request after done.
- **Same-cycle set/clear:** an edge on `src_in[4]` coincides with the ack of vector 4 -> `pending[4]` remains 1 and a second request follows done.
- **Ignored handshake inputs:** `irq_done` in IDLE or REQ and `irq_ack` in SERVICE -> no state change. Ack and done together in REQ -> enters SERVICE.
- **Reset mid-service:** assert `rst_n`=0 in SERVICE -> `req_interrupt`=0, `irq_vector`=0, `pending`=0 and mask=all ones, with no clock edge required.

Source files
------------

// File: rtl/interrupt_ctrl_pkg.sv
// Shared CPU-side definitions: interrupt FSM encoding and the default source count.
package pkg_cpu;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } IrqState;

  localparam int CPU_NUM_IRQ_SRC = 8;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for asynchronous interrupt lines; all stages clear on reset.
module irq_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: edge/level capture, mask, lowest-index priority, req/ack/done handshake.
// States: IRQ_IDLE = wait for eligible source | IRQ_REQ = request raised | IRQ_SERVICE = CPU servicing
module interrupt_ctrl
  import pkg_cpu::*;
#(
  parameter int NUM_SRC     = CPU_NUM_IRQ_SRC,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_in,
  input  logic [NUM_SRC-1:0]         edge_mode,
  input  logic                       mask_wr_en,
  input  logic [NUM_SRC-1:0]         mask_wr_data,
  input  logic                       irq_ack,
  input  logic                       irq_done,
  output logic                       req_interrupt,
  output logic [$clog2(NUM_SRC)-1:0] irq_vector,
  output logic [NUM_SRC-1:0]         pending
);

  localparam int VEC_W = $clog2(NUM_SRC);

  function automatic logic [VEC_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] vec);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) lowest_idx = VEC_W'(i);
    end
  endfunction

  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] eligible;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               req_q;
  logic               ack_take;
  IrqState            state_q, state_d;

  irq_sync #(
    .WIDTH  (NUM_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (src_in),
    .q_o   (sync)
  );

  assign ack_take = (state_q == IRQ_REQ) && irq_ack;
  assign eligible = pending_q & ~mask_q;
  assign mask_d   = mask_wr_en ? mask_wr_data : mask_q;

  // A new rising edge outranks the ack clear so a back-to-back event is not lost.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_mode[i]) begin
        pending_d[i] = (sync[i] & ~sync_q[i]) |
                       (pending_q[i] & ~(ack_take && (vec_q == VEC_W'(i))));
      end else begin
        pending_d[i] = sync[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IRQ_IDLE: begin
        if (|eligible) begin
          vec_d   = lowest_idx(eligible);
          state_d = IRQ_REQ;
        end
      end
      IRQ_REQ:     if (irq_ack)  state_d = IRQ_SERVICE;
      IRQ_SERVICE: if (irq_done) state_d = IRQ_IDLE;
      default:     state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IRQ_IDLE;
      vec_q     <= '0;
      req_q     <= 1'b0;
      sync_q    <= '0;
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      req_q     <= (state_d == IRQ_REQ);
      sync_q    <= sync;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  assign req_interrupt = req_q;
  assign irq_vector    = vec_q;
  assign pending       = pending_q;

endmodule
